// File: rtl/btn_pkg.sv
// btn_pkg: shared types and default timing constants for the button conditioner.
package btn_pkg;
    typedef enum logic [1:0] {RS_IDLE, RS_DELAY, RS_REPEAT, RS_HOLD} rep_state_t;
    localparam int CLK_HZ = 100_000_000;
    localparam int DEF_DEBOUNCE_CYC = CLK_HZ / 100;
    localparam int DEF_REPEAT_DELAY = CLK_HZ / 2;
    localparam int DEF_REPEAT_PERIOD = CLK_HZ / 10;
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/btn_debounce_chan.sv
// btn_debounce_chan: one button channel with synchronizer, debounce counter and typematic repeat FSM.
module btn_debounce_chan
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press,
    output logic rel,
    output logic rep
);
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    localparam int RW = $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD) + 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYC - 1);
    localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

    logic s1, s2, flip, rise, fall, rep_n;
    logic [CW-1:0] cnt;
    logic [RW-1:0] rcnt, rcnt_n;
    rep_state_t st, st_n;

    assign flip = (s2 != level) && (cnt == DEB_LAST);
    assign rise = flip & s2;
    assign fall = flip & ~s2;

    // A release always wins over a repeat that would fire in the same cycle.
    always_comb begin
        st_n = st;
        rcnt_n = rcnt + 1'b1;
        rep_n = 1'b0;
        if (fall) begin
            st_n = RS_IDLE;
            rcnt_n = '0;
        end else begin
            case (st)
                RS_IDLE: begin
                    rcnt_n = '0;
                    if (rise) begin
                        rep_n = 1'b1;
                        st_n = (REPEAT_DELAY == 0) ? RS_HOLD : RS_DELAY;
                    end
                end
                RS_DELAY: if (rcnt == DLY_LAST) begin
                    rep_n = 1'b1;
                    rcnt_n = '0;
                    st_n = RS_REPEAT;
                end
                RS_REPEAT: if (rcnt == PER_LAST) begin
                    rep_n = 1'b1;
                    rcnt_n = '0;
                end
                default: rcnt_n = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            level <= 1'b0;
            cnt <= '0;
            press <= 1'b0;
            rel <= 1'b0;
            rep <= 1'b0;
            st <= RS_IDLE;
            rcnt <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            cnt <= (s2 == level || flip) ? '0 : cnt + 1'b1;
            if (flip) level <= s2;
            press <= rise;
            rel <= fall;
            rep <= rep_n;
            st <= st_n;
            rcnt <= rcnt_n;
        end
    end
endmodule

// File: rtl/btn_debounce_repeat.sv
// btn_debounce_repeat: debounces N_BTN raw pushbuttons and produces level, press, release and typematic pulses.
module btn_debounce_repeat
    import btn_pkg::*;
#(
    parameter int N_BTN = 5,
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_rep
);
    if (N_BTN < 1) $error("N_BTN must be at least 1");
    if (DEBOUNCE_CYC < 1) $error("DEBOUNCE_CYC must be at least 1");
    if (REPEAT_DELAY < 0) $error("REPEAT_DELAY must not be negative");
    if (REPEAT_PERIOD < 1) $error("REPEAT_PERIOD must be at least 1");

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        btn_debounce_chan #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC),
            .REPEAT_DELAY(REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
        ) u_chan (
            .clk(clk),
            .reset(reset),
            .raw(btn_raw[i]),
            .level(btn_level[i]),
            .press(btn_press[i]),
            .rel(btn_release[i]),
            .rep(btn_rep[i])
        );
    end
endmodule
